switch_debounce_monitor: RTL and testbench

Input-side counterpart to the switch/LED datapath. It samples the raw board switches, synchronizes and debounces them, and reports each change as a handshaked event. Each event carries the changed-bit mask, the rising-edge mask and a snapshot of the debounced value. Downstream logic, such as LED/7-segment drivers or a controller FSM, consumes clean switch state and change events instead of raw SWITCH_I.

---
 rtl/switch_debounce_monitor.sv | 186 ++++++++++++++++++
 tb/tb_switch_debounce_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_monitor.sv
// Synchronizes and debounces raw board switches and reports each change as a handshaked event.
// Define SWITCH_SYNC_3STAGE_EN to use a 3-flop input synchronizer instead of the default 2-flop one.
module switch_debounce_monitor #(
    parameter int NUM_SW     = 18,
    parameter int SAMPLE_DIV = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic              CLOCK_50_I,
    input  logic              RESETN_I,
    input  logic [NUM_SW-1:0] SWITCH_I,
    output logic [NUM_SW-1:0] SWITCH_DB_O,
    output logic              EVENT_VALID_O,
    input  logic              EVENT_READY_I,
    output logic [NUM_SW-1:0] EVENT_MASK_O,
    output logic [NUM_SW-1:0] EVENT_RISE_O,
    output logic [NUM_SW-1:0] EVENT_VALUE_O,
    output logic [15:0]       EVENT_COUNT_O,
    output logic              OVERRUN_O
);

`ifdef SWITCH_SYNC_3STAGE_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int              PW       = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0]   DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [2:0]      CNT_LAST = 3'(STABLE_CNT - 1);

    generate
        if (SAMPLE_DIV < 2) begin : g_bad_div
            $error("SAMPLE_DIV must be at least 2");
        end
        if (STABLE_CNT < 1 || STABLE_CNT > 7) begin : g_bad_cnt
            $error("STABLE_CNT must be in 1..7");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizer: stage 0 samples the raw pins, last stage is used.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_SW-1:0] sync_q;
    logic [NUM_SW-1:0]                  sync;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SWITCH_I};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    assign tick    = (presc_q == DIV_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce counters and debounced level
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0][2:0] cnt_q;
    logic [NUM_SW-1:0][2:0] cnt_d;
    logic [NUM_SW-1:0]      db_q;
    logic [NUM_SW-1:0]      db_d;
    logic [NUM_SW-1:0]      flip;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        flip  = '0;
        if (tick) begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i] = '0;
                    flip[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    assign db_d = db_q ^ flip;

    // NOTE: the counter bank is reset because a reset must discard any partial debounce history.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            cnt_q <= '0;
            db_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    // ------------------------------------------------------------------
    // Event register: load on a fresh flip, merge into a pending one.
    // ------------------------------------------------------------------
    logic              valid_q,   valid_d;
    logic [NUM_SW-1:0] mask_q,    mask_d;
    logic [NUM_SW-1:0] rise_q,    rise_d;
    logic [NUM_SW-1:0] value_q,   value_d;
    logic [15:0]       count_q,   count_d;
    logic              overrun_q, overrun_d;
    logic              accept;
    logic [NUM_SW-1:0] merged_mask;

    assign accept      = valid_q & EVENT_READY_I;
    assign merged_mask = mask_q | flip;

    always_comb begin
        valid_d   = valid_q;
        mask_d    = mask_q;
        rise_d    = rise_q;
        value_d   = value_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (|flip) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                mask_d  = flip;
                value_d = db_d;
                rise_d  = flip & db_d;
            end else begin
                // Consumer is stalled: fold the new flips in and flag the loss of granularity.
                mask_d    = merged_mask;
                value_d   = db_d;
                rise_d    = merged_mask & db_d;
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            valid_q   <= 1'b0;
            mask_q    <= '0;
            rise_q    <= '0;
            value_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            rise_q    <= rise_d;
            value_q   <= value_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign SWITCH_DB_O   = db_q;
    assign EVENT_VALID_O = valid_q;
    assign EVENT_MASK_O  = mask_q;
    assign EVENT_RISE_O  = rise_q;
    assign EVENT_VALUE_O = value_q;
    assign EVENT_COUNT_O = count_q;
    assign OVERRUN_O     = overrun_q;

endmodule

// File: tb/tb_switch_debounce_monitor.sv
// Directed bench for switch_debounce_monitor with SAMPLE_DIV=4, STABLE_CNT=3.
// Edge numbers are counted by the bench from each reset release; ticks land on multiples of 4.
module tb_switch_debounce_monitor;

    localparam int NUM_SW = 18;

`ifdef SWITCH_SYNC_3STAGE_EN
    localparam bit SYNC3 = 1'b1;
`else
    localparam bit SYNC3 = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] db;
    logic              ev_valid;
    logic              ev_ready;
    logic [NUM_SW-1:0] ev_mask;
    logic [NUM_SW-1:0] ev_rise;
    logic [NUM_SW-1:0] ev_value;
    logic [15:0]       ev_count;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    switch_debounce_monitor #(
        .NUM_SW    (NUM_SW),
        .SAMPLE_DIV(4),
        .STABLE_CNT(3)
    ) dut (
        .CLOCK_50_I   (clk),
        .RESETN_I     (rst_n),
        .SWITCH_I     (sw),
        .SWITCH_DB_O  (db),
        .EVENT_VALID_O(ev_valid),
        .EVENT_READY_I(ev_ready),
        .EVENT_MASK_O (ev_mask),
        .EVENT_RISE_O (ev_rise),
        .EVENT_VALUE_O(ev_value),
        .EVENT_COUNT_O(ev_count),
        .OVERRUN_O    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge number e (relative to last reset release).
    task automatic goto(input int e);
        repeat (e - cyc) @(posedge clk);
        #1;
        cyc = e;
    endtask

    task automatic check_event(input string tag, input logic [31:0] m, input logic [31:0] r,
                               input logic [31:0] v);
        check({tag, ".valid"}, 32'(ev_valid), 32'd1);
        check({tag, ".mask"},  32'(ev_mask),  m);
        check({tag, ".rise"},  32'(ev_rise),  r);
        check({tag, ".value"}, 32'(ev_value), v);
        check({tag, ".db"},    32'(db),       v);
    endtask

    initial begin
        rst_n    = 1'b0;
        sw       = 18'h00001;
        ev_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.db",      32'(db),       32'h0);
        check("rst.valid",   32'(ev_valid), 32'h0);
        check("rst.mask",    32'(ev_mask),  32'h0);
        check("rst.count",   32'(ev_count), 32'h0);
        check("rst.overrun", 32'(overrun),  32'h0);

        // 1: switch held high through reset debounces after three ticks (e4, e8, e12).
        rst_n = 1'b1;
        cyc   = 0;
        goto(11);
        check("s1.db_early",    32'(db),       32'h0);
        check("s1.valid_early", 32'(ev_valid), 32'h0);
        goto(12);
        check_event("s1", 32'h1, 32'h1, 32'h1);
        check("s1.count_pre", 32'(ev_count), 32'h0);
        goto(13);
        check("s1.valid_post", 32'(ev_valid), 32'h0);
        check("s1.count",      32'(ev_count), 32'h1);

        // 2: bit 1 bounces 1 (counted at e20), 0 (clears at e24), then holds 1 (e28, e32, e36).
        goto(16);
        sw = 18'h00003;
        goto(19);
        sw = 18'h00001;
        goto(22);
        sw = 18'h00003;
        goto(27);
        check("s2.valid_bounce", 32'(ev_valid), 32'h0);
        check("s2.db_bounce",    32'(db),       32'h1);
        goto(35);
        check("s2.valid_early", 32'(ev_valid), 32'h0);
        check("s2.db_early",    32'(db),       32'h1);
        goto(36);
        check_event("s2", 32'h2, 32'h2, 32'h3);
        goto(37);
        check("s2.valid_post", 32'(ev_valid), 32'h0);
        check("s2.count",      32'(ev_count), 32'h2);

        // Falling edge of bit 1 returns the state to 0x00001.
        goto(40);
        sw = 18'h00001;
        goto(52);
        check_event("fall", 32'h2, 32'h0, 32'h1);
        goto(53);
        check("fall.count", 32'(ev_count), 32'h3);

        // 3: 0x00001 -> 0x00006 in one cycle yields a single three-bit event.
        goto(56);
        sw = 18'h00006;
        goto(67);
        check("s3.db_early",    32'(db),       32'h1);
        check("s3.valid_early", 32'(ev_valid), 32'h0);
        goto(68);
        check_event("s3", 32'h7, 32'h6, 32'h6);
        goto(69);
        check("s3.valid_post", 32'(ev_valid), 32'h0);
        check("s3.count",      32'(ev_count), 32'h4);

        // 4: consumer stalled; bit 0 rises (flip e84), then bit 3 rises and merges (e100).
        goto(72);
        ev_ready = 1'b0;
        sw       = 18'h00007;
        goto(84);
        check_event("s4a", 32'h1, 32'h1, 32'h7);
        check("s4a.overrun", 32'(overrun), 32'h0);
        goto(88);
        sw = 18'h0000F;
        goto(99);
        check("s4.hold_valid", 32'(ev_valid), 32'h1);
        check("s4.hold_mask",  32'(ev_mask),  32'h1);
        check("s4.hold_value", 32'(ev_value), 32'h7);
        goto(100);
        check_event("s4b", 32'h9, 32'h9, 32'hF);
        check("s4b.overrun", 32'(overrun),  32'h1);
        check("s4b.count",   32'(ev_count), 32'h4);
        goto(101);
        ev_ready = 1'b1;
        goto(102);
        check("s4.valid_post",   32'(ev_valid), 32'h0);
        check("s4.count",        32'(ev_count), 32'h5);
        check("s4.overrun_keep", 32'(overrun),  32'h1);
        goto(104);
        check("idle_ready.count", 32'(ev_count), 32'h5);
        check("idle_ready.valid", 32'(ev_valid), 32'h0);

        // 5: bit 3 falls, two of three ticks seen (e108, e112), then reset mid-debounce.
        sw = 18'h00007;
        goto(113);
        check("s5.db_pre", 32'(db), 32'hF);
        rst_n = 1'b0;
        #1;
        check("s5.rst_db",      32'(db),       32'h0);
        check("s5.rst_valid",   32'(ev_valid), 32'h0);
        check("s5.rst_count",   32'(ev_count), 32'h0);
        check("s5.rst_overrun", 32'(overrun),  32'h0);
        check("s5.rst_value",   32'(ev_value), 32'h0);
        goto(115);
        rst_n = 1'b1;
        cyc   = 0;
        goto(11);
        check("s5.db_early",    32'(db),       32'h0);
        check("s5.valid_early", 32'(ev_valid), 32'h0);
        goto(12);
        check_event("s5", 32'h7, 32'h7, 32'h7);
        goto(13);
        check("s5.count",   32'(ev_count), 32'h1);
        check("s5.overrun", 32'(overrun),  32'h0);

        // 6: change lands one edge after a tick; a 3-flop synchronizer misses tick e20.
        goto(17);
        sw = 18'h00005;
        goto(28);
        check("s6.valid_e28", 32'(ev_valid), SYNC3 ? 32'h0 : 32'h1);
        check("s6.db_e28",    32'(db),       SYNC3 ? 32'h7 : 32'h5);
        goto(32);
        check("s6.db_e32",    32'(db),       32'h5);
        check("s6.valid_e32", 32'(ev_valid), SYNC3 ? 32'h1 : 32'h0);
        goto(33);
        check("s6.count", 32'(ev_count), 32'h2);
        check("s6.mask",  32'(ev_mask),  32'h2);
        check("s6.rise",  32'(ev_rise),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
